// File: rtl/demux_1_8_cmpnt_pkg.sv
// ----------------------------------------------------------------------------
// demux_1_8_pkg
//   Shared widths and types for the registered 1-to-8 demultiplexer slice.
//
//   Contents:
//     SEL_W   width of the binary destination index (3)
//     N_OUT   number of output lines (8)
//     sel_t   destination index type
//     code_t  output line vector type, bit k = line k
//
//   Configuration: the optional clock enable is controlled by the macro
//   DEMUX_1_8_CE_EN in the interface and top files, not here.
// ----------------------------------------------------------------------------
package demux_1_8_pkg;

    localparam int SEL_W = 3;
    localparam int N_OUT = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_OUT-1:0] code_t;

endpackage : demux_1_8_pkg

// File: rtl/demux_1_8_cmpnt_if.sv
// ----------------------------------------------------------------------------
// demux_1_8_cmpnt_if
//   Signal bundle for the registered 1-to-8 demultiplexer.
//
//   Signals:
//     i_a         data bit to be routed
//     i_sel_code  binary index of the destination line (0..7)
//     o_code      registered demux output, 0 or one-hot
//     i_ce        clock enable, present only when DEMUX_1_8_CE_EN is defined
//
//   Modports:
//     master  the steering source: drives i_a/i_sel_code(/i_ce), reads o_code
//     slave   the demux itself: reads the inputs, drives o_code
//
//   Handshake: none. A new (i_a, i_sel_code) pair is accepted on every
//   rising clock edge (qualified by i_ce when present) and appears on
//   o_code exactly one clock later. There is no valid/ready pair.
// ----------------------------------------------------------------------------
interface demux_1_8_cmpnt_if;
    import demux_1_8_pkg::*;

    logic  i_a;
    sel_t  i_sel_code;
    code_t o_code;

`ifdef DEMUX_1_8_CE_EN
    logic  i_ce;

    modport master (
        output i_a,
        output i_sel_code,
        output i_ce,
        input  o_code
    );

    modport slave (
        input  i_a,
        input  i_sel_code,
        input  i_ce,
        output o_code
    );
`else
    modport master (
        output i_a,
        output i_sel_code,
        input  o_code
    );

    modport slave (
        input  i_a,
        input  i_sel_code,
        output o_code
    );
`endif

endinterface : demux_1_8_cmpnt_if

// File: rtl/demux_1_8_cmpnt_decoder_3_8.sv
// ----------------------------------------------------------------------------
// decoder_3_8
//   Purely combinational 3-to-8 one-hot decoder.
//
//   Ports:
//     sel     in   sel_t   binary line index
//     onehot  out  code_t  onehot[k] = (sel == k); exactly one bit set
// ----------------------------------------------------------------------------
module decoder_3_8
    import demux_1_8_pkg::*;
(
    input  sel_t  sel,
    output code_t onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < N_OUT; k++) begin
            onehot[k] = (sel == sel_t'(k));
        end
    end

endmodule : decoder_3_8

// File: rtl/demux_1_8_cmpnt.sv
// ----------------------------------------------------------------------------
// demux_1_8_cmpnt
//   Registered 1-to-8 demultiplexer. The data bit bus.i_a is steered onto the
//   single o_code line selected by bus.i_sel_code; all other lines are 0.
//   Built as a 3-to-8 decoder, gated bitwise by i_a, feeding an 8-bit
//   register. Clocked drop-in for the combinational 1:8 demux.
//
//   Ports:
//     i_clk  in   1  system clock, all updates on the rising edge
//     i_rst  in   1  synchronous, active-high reset; clears o_code and
//                    overrides every other input including i_ce
//     bus    slave modport of demux_1_8_cmpnt_if
//              i_a, i_sel_code (, i_ce) in; o_code out
//
//   Configuration:
//     DEMUX_1_8_CE_EN  when defined, bus.i_ce qualifies loading; with i_ce=0
//                      o_code holds. When undefined, o_code loads on every
//                      non-reset edge.
//
//   Latency: 1 clock from (i_a, i_sel_code) to o_code. No handshake.
// ----------------------------------------------------------------------------
module demux_1_8_cmpnt
    import demux_1_8_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    demux_1_8_cmpnt_if.slave   bus
);

    code_t dec_onehot;
    code_t next_code;
    code_t code_q;
    logic  load_en;

    decoder_3_8 u_decoder (
        .sel    (bus.i_sel_code),
        .onehot (dec_onehot)
    );

    // The decoder output is always one-hot, so gating it with i_a keeps the
    // register input either all-zero or one-hot by construction.
    assign next_code = dec_onehot & {N_OUT{bus.i_a}};

`ifdef DEMUX_1_8_CE_EN
    assign load_en = bus.i_ce;
`else
    assign load_en = 1'b1;
`endif

    // Reset is tested first so it wins over the clock enable in both builds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            code_q <= '0;
        end else if (load_en) begin
            code_q <= next_code;
        end
    end

    assign bus.o_code = code_q;

endmodule : demux_1_8_cmpnt

// File: tb/tb_demux_1_8_cmpnt.sv
// ----------------------------------------------------------------------------
// tb_demux_1_8_cmpnt
//   Bench for demux_1_8_cmpnt: directed scenarios with pinned literal values
//   followed by randomized traffic, checked every cycle against a behavioural
//   model of the routing rule.
// ----------------------------------------------------------------------------
module tb_demux_1_8_cmpnt;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce_v = 1'b1;

    demux_1_8_cmpnt_if bus ();

    demux_1_8_cmpnt dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

`ifdef DEMUX_1_8_CE_EN
    assign bus.i_ce = ce_v;
`endif

    // ---------------- model state ----------------
    logic [7:0] exp_code = 8'h00;
    logic [7:0] exp_q[$];          // literal expectations, one per edge
    logic       lit_en   = 1'b0;
    logic [7:0] lit_val  = 8'h00;
    string      lit_name = "";
    logic       lit_en_q   = 1'b0;
    logic [7:0] lit_val_q  = 8'h00;
    string      lit_name_q = "";
    logic       check_en = 1'b0;

    int checks = 0;
    int errors = 0;

    // Behavioural model: at each edge the output becomes the data bit placed
    // at position sel (or nothing), unless held or cleared.
    always @(posedge clk) begin
        if (rst) begin
            exp_code = 8'h00;
        end else if (ce_v) begin
            exp_code = bus.i_a ? (8'h01 << bus.i_sel_code) : 8'h00;
        end
        lit_en_q   = lit_en;
        lit_val_q  = lit_val;
        lit_name_q = lit_name;
        if (lit_en) exp_q.push_back(lit_val);
    end

    // Single compare process, half a cycle after each edge.
    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (bus.o_code !== exp_code) begin
                errors++;
                $display("FAIL model t=%0t o_code=%02h expected=%02h", $time, bus.o_code, exp_code);
            end
            checks++;
            if (!$onehot0(bus.o_code) || $isunknown(bus.o_code)) begin
                errors++;
                $display("FAIL onehot0 t=%0t o_code=%02h", $time, bus.o_code);
            end
            if (lit_en_q && exp_q.size() > 0) begin
                logic [7:0] lv;
                lv = exp_q.pop_front();
                checks++;
                if (bus.o_code !== lv) begin
                    errors++;
                    $display("FAIL %s o_code=%02h expected=%02h", lit_name_q, bus.o_code, lv);
                end
                checks++;
                if (exp_code !== lv) begin
                    errors++;
                    $display("FAIL model_pin_%s model=%02h expected=%02h", lit_name_q, exp_code, lv);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Applies one input set for the next rising edge; optionally attaches a
    // hand-computed expectation for the output produced by that edge.
    task automatic cyc(input logic r, input logic a, input logic [2:0] s,
                       input logic c, input logic has_lit,
                       input logic [7:0] lv, input string nm);
        @(posedge clk);
        #2;
        rst            = r;
        bus.i_a        = a;
        bus.i_sel_code = s;
        ce_v           = c;
        lit_en         = has_lit;
        lit_val        = lv;
        lit_name       = nm;
    endtask

    initial begin
        logic [3:0] v;
        bus.i_a        = 1'b1;
        bus.i_sel_code = 3'd5;

        // Reset with i_a=1, sel=5 must still give zero; release gives 8'h20.
        cyc(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 8'h00, "reset");
        @(posedge clk);
        #1 check_en = 1'b1;
        #1;
        rst      = 1'b0;
        lit_en   = 1'b1;
        lit_val  = 8'h20;
        lit_name = "reset_release";

        // Exhaustive sweep of {i_a, sel}.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            cyc(1'b0, v[3], v[2:0], 1'b1, 1'b1,
                v[3] ? (8'h01 << v[2:0]) : 8'h00, "sweep");
        end
        cyc(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h08, "sweep_1011");

        // Back-to-back selection change.
        cyc(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 8'h01, "b2b_sel0");
        cyc(1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 8'h80, "b2b_sel7");
        cyc(1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 8'h00, "a0_sel7");

        // Mid-stream reset.
        cyc(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h08, "mid_pre");
        cyc(1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 8'h00, "mid_rst");
        cyc(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h08, "mid_resume");

`ifdef DEMUX_1_8_CE_EN
        cyc(1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 8'h08, "ce_hold_a");
        cyc(1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'h08, "ce_hold_b");
        cyc(1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h00, "ce_rst");
        cyc(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 8'h00, "ce_hold_zero");
        cyc(1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 8'h04, "ce_load");
`endif

        // Randomized traffic, model-checked only.
        for (int i = 0; i < 300; i++) begin
            logic r;
            logic c;
            r = ($urandom_range(0, 15) == 0);
`ifdef DEMUX_1_8_CE_EN
            c = ($urandom_range(0, 3) != 0);
`else
            c = 1'b1;
`endif
            cyc(r, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                c, 1'b0, 8'h00, "");
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demux_1_8_cmpnt
